// File: rtl/control_pipe_if.sv
// control_pipe_if: ID-stage instruction fields in, per-stage control bundle out.
interface control_pipe_if #(
  parameter int REG_W   = 5,
  parameter int ALUOP_W = 4
);
  logic [5:0]         i_op;
  logic [5:0]         i_func;
  logic [REG_W-1:0]   i_rs;
  logic [REG_W-1:0]   i_rt;
  logic [REG_W-1:0]   i_rd;
  logic               i_valid;
  logic               i_flush;
  logic               i_halt;
  logic               o_stall;
  logic [ALUOP_W-1:0] o_ex_ALUop;
  logic               o_ex_ALUsrc;
  logic               o_ex_RegDst;
  logic               o_ex_shmat;
  logic               o_ex_illegal;
  logic               o_mem_MemRead;
  logic               o_mem_MemWrite;
  logic [2:0]         o_mem_load_store_type;
  logic               o_wb_RegWrite;
  logic               o_wb_MemtoReg;
  logic [REG_W-1:0]   o_wb_dest;
  modport master (
    output i_op, i_func, i_rs, i_rt, i_rd, i_valid, i_flush, i_halt,
    input  o_stall, o_ex_ALUop, o_ex_ALUsrc, o_ex_RegDst, o_ex_shmat, o_ex_illegal,
    input  o_mem_MemRead, o_mem_MemWrite, o_mem_load_store_type,
    input  o_wb_RegWrite, o_wb_MemtoReg, o_wb_dest
  );
  modport slave (
    input  i_op, i_func, i_rs, i_rt, i_rd, i_valid, i_flush, i_halt,
    output o_stall, o_ex_ALUop, o_ex_ALUsrc, o_ex_RegDst, o_ex_shmat, o_ex_illegal,
    output o_mem_MemRead, o_mem_MemWrite, o_mem_load_store_type,
    output o_wb_RegWrite, o_wb_MemtoReg, o_wb_dest
  );
endinterface

// File: rtl/control_pipe.sv
// control_pipe: MIPS-style ID decode feeding an EX/MEM/WB control pipeline with load-use stall, flush and halt.
module control_pipe #(
  parameter int REG_W     = 5,
  parameter int ALUOP_W   = 4,
  parameter bit HAZARD_EN = 1'b1
) (
  input logic i_clk,
  input logic i_reset,
  control_pipe_if.slave p
);
  logic [3:0]         d_alu;
  logic               d_src, d_rdst, d_sh, d_ill, d_mr, d_mw, d_rw, d_m2r, r_alu, imm_wr;
  logic [2:0]         d_ls;
  logic [REG_W-1:0]   d_dest;
  logic [ALUOP_W-1:0] ex_alu;
  logic               ex_src, ex_rdst, ex_sh, ex_ill, ex_mr, ex_mw, ex_rw, ex_m2r;
  logic [2:0]         ex_ls;
  logic [REG_W-1:0]   ex_dest;
  logic               mem_mr, mem_mw, mem_rw, mem_m2r;
  logic [2:0]         mem_ls;
  logic [REG_W-1:0]   mem_dest;
  logic               wb_rw, wb_m2r;
  logic [REG_W-1:0]   wb_dest;
  logic               load_use, bubble;
  always_comb begin
    d_alu  = '0;
    d_src  = 1'b0;
    d_rdst = 1'b0;
    d_sh   = 1'b0;
    d_ill  = 1'b0;
    d_mr   = 1'b0;
    d_mw   = 1'b0;
    d_rw   = 1'b0;
    d_m2r  = 1'b0;
    d_ls   = '0;
    d_dest = '0;
    r_alu  = 1'b0;
    imm_wr = 1'b0;
    if (p.i_op == 6'h00) begin
      case (p.i_func)
        6'h20, 6'h21: r_alu = 1'b1;
        6'h22, 6'h23: begin r_alu = 1'b1; d_alu = 4'd1; end
        6'h24:        begin r_alu = 1'b1; d_alu = 4'd2; end
        6'h25:        begin r_alu = 1'b1; d_alu = 4'd3; end
        6'h26:        begin r_alu = 1'b1; d_alu = 4'd4; end
        6'h27:        begin r_alu = 1'b1; d_alu = 4'd5; end
        6'h2A:        begin r_alu = 1'b1; d_alu = 4'd6; end
        6'h00:        begin r_alu = 1'b1; d_alu = 4'd7; d_sh = 1'b1; end
        6'h02:        begin r_alu = 1'b1; d_alu = 4'd8; d_sh = 1'b1; end
        6'h03:        begin r_alu = 1'b1; d_alu = 4'd9; d_sh = 1'b1; end
        6'h04:        begin r_alu = 1'b1; d_alu = 4'd7; end
        6'h06:        begin r_alu = 1'b1; d_alu = 4'd8; end
        6'h07:        begin r_alu = 1'b1; d_alu = 4'd9; end
        6'h08:        ;
        6'h09:        r_alu = 1'b1;
        default:      d_ill = 1'b1;
      endcase
    end else begin
      case (p.i_op)
        6'h02:        ;
        6'h03:        begin d_rw = 1'b1; d_dest = REG_W'(31); end
        6'h04, 6'h05: d_alu = 4'd1;
        6'h08:        imm_wr = 1'b1;
        6'h0A:        begin imm_wr = 1'b1; d_alu = 4'd6; end
        6'h0C:        begin imm_wr = 1'b1; d_alu = 4'd2; end
        6'h0D:        begin imm_wr = 1'b1; d_alu = 4'd3; end
        6'h0E:        begin imm_wr = 1'b1; d_alu = 4'd4; end
        6'h0F:        begin imm_wr = 1'b1; d_alu = 4'd10; end
        // low opcode bits already encode {unsigned, size} for loads and stores
        6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin imm_wr = 1'b1; d_mr = 1'b1; d_m2r = 1'b1; d_ls = p.i_op[2:0]; end
        6'h28, 6'h29, 6'h2B:               begin d_src = 1'b1; d_mw = 1'b1; d_ls = p.i_op[2:0]; end
        default:      d_ill = 1'b1;
      endcase
    end
    if (r_alu) begin
      d_rdst = 1'b1;
      d_rw   = 1'b1;
      d_dest = p.i_rd;
    end
    if (imm_wr) begin
      d_src  = 1'b1;
      d_rw   = 1'b1;
      d_dest = p.i_rt;
    end
  end
  assign load_use  = HAZARD_EN && p.i_valid && ex_mr && (ex_dest != '0) && (ex_dest == p.i_rs || ex_dest == p.i_rt);
  assign p.o_stall = i_reset && (p.i_halt || (load_use && !p.i_flush));
  assign bubble    = !p.i_valid || p.i_flush || load_use;
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      {ex_alu, ex_src, ex_rdst, ex_sh, ex_ill, ex_mr, ex_mw, ex_rw, ex_m2r, ex_ls, ex_dest} <= '0;
      {mem_mr, mem_mw, mem_rw, mem_m2r, mem_ls, mem_dest} <= '0;
      {wb_rw, wb_m2r, wb_dest} <= '0;
    end else if (!p.i_halt) begin
      ex_alu   <= bubble ? '0 : ALUOP_W'(d_alu);
      ex_src   <= !bubble && d_src;
      ex_rdst  <= !bubble && d_rdst;
      ex_sh    <= !bubble && d_sh;
      ex_ill   <= !bubble && d_ill;
      ex_mr    <= !bubble && d_mr;
      ex_mw    <= !bubble && d_mw;
      ex_rw    <= !bubble && d_rw;
      ex_m2r   <= !bubble && d_m2r;
      ex_ls    <= bubble ? '0 : d_ls;
      ex_dest  <= bubble ? '0 : d_dest;
      mem_mr   <= ex_mr;
      mem_mw   <= ex_mw;
      mem_rw   <= ex_rw;
      mem_m2r  <= ex_m2r;
      mem_ls   <= ex_ls;
      mem_dest <= ex_dest;
      wb_rw    <= mem_rw;
      wb_m2r   <= mem_m2r;
      wb_dest  <= mem_dest;
    end
  end
  assign p.o_ex_ALUop            = ex_alu;
  assign p.o_ex_ALUsrc           = ex_src;
  assign p.o_ex_RegDst           = ex_rdst;
  assign p.o_ex_shmat            = ex_sh;
  assign p.o_ex_illegal          = ex_ill;
  assign p.o_mem_MemRead         = mem_mr;
  assign p.o_mem_MemWrite        = mem_mw;
  assign p.o_mem_load_store_type = mem_ls;
  assign p.o_wb_RegWrite         = wb_rw && (wb_dest != '0);
  assign p.o_wb_MemtoReg         = wb_m2r;
  assign p.o_wb_dest             = wb_dest;
endmodule

// File: doc/control_pipe.md
CONTROL_PIPE -- requirements
Module: control_pipe

Interface
REQ-001 SHALL have parameter REG_W, default 5, meaning register-address width.
REQ-002 SHALL have parameter ALUOP_W, default 4, meaning ALU-operation code width (min 4).
REQ-003 SHALL have parameter HAZARD_EN, default 1, meaning load-use stall logic present (0 = never stall).
REQ-004 SHALL have port i_clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port i_reset  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_op / i_func  input  6 / 6  opcode and function field of the ID-stage instruction.
REQ-007 SHALL have port i_rs / i_rt / i_rd  input  REG_W each  register fields of the ID-stage instruction.
REQ-008 SHALL have port i_valid  input  1  ID-stage instruction valid.
REQ-009 SHALL have ports i_flush  input  1  kill the ID-stage instruction; i_halt  input  1  freeze pipeline.
REQ-010 SHALL have port o_stall  output  1  combinational; hold PC and IF/ID.
REQ-011 SHALL have EX-stage outputs o_ex_ALUop (ALUOP_W), o_ex_ALUsrc, o_ex_RegDst, o_ex_shmat, o_ex_illegal (1 each).
REQ-012 SHALL have MEM-stage outputs o_mem_MemRead, o_mem_MemWrite (1 each), o_mem_load_store_type (3).
REQ-013 SHALL have WB-stage outputs o_wb_RegWrite, o_wb_MemtoReg (1 each), o_wb_dest (REG_W); EX and MEM stages also carry dest internally.

Function
REQ-014 SHALL decode combinationally in ID: ADD/ADDU/ADDI/loads/stores->ALUop 0, SUB/SUBU/BEQ/BNE->1, AND/ANDI->2, OR/ORI->3, XOR/XORI->4, NOR->5, SLT/SLTI->6, SLL/SLLV->7, SRL/SRLV->8, SRA/SRAV->9, LUI->10.
REQ-015 SHALL set RegDst=1 and dest=i_rd for R-type ALU ops and JALR; dest=i_rt for I-type writes; dest=31 for JAL.
REQ-016 SHALL set shmat=1 only for SLL/SRL/SRA; ALUsrc=1 for loads, stores, ADDI, ANDI, ORI, XORI, LUI, SLTI.
REQ-017 SHALL set RegWrite=1 for all R-type ALU ops, loads, ALU immediates, LUI, JAL, JALR; 0 for stores, branches, J, JR.
REQ-018 SHALL set load_store_type: bit2 = unsigned, [1:0] = 0 byte/1 half/3 word (LB 000, LH 001, LW 011, LBU 100, LHU 101, SB 000, SH 001, SW 011).
REQ-019 SHALL treat an undecoded op/func as a bubble (all controls 0) with illegal=1.
REQ-020 SHALL register the bundle ID->EX->MEM->WB, one cycle per stage: EX outputs latency 1, MEM 2, WB 3 from a decoded ID instruction.
REQ-021 SHALL insert a bubble (all controls 0, illegal 0) into EX when i_valid=0.
REQ-022 SHALL (HAZARD_EN=1) assert o_stall when EX stage has MemRead=1, dest!=0, and dest equals i_rs or i_rt, with i_valid=1.
REQ-023 SHALL during a load-use stall insert a bubble into EX while MEM and WB advance; the stall lasts exactly one cycle.
REQ-024 SHALL on i_flush=1 insert a bubble into EX, override a simultaneous load-use stall (o_stall=0), and let MEM/WB advance.
REQ-025 SHALL on i_halt=1 hold all three stage registers, force o_stall=1, and override i_flush and load-use bubbles.
REQ-026 SHALL never assert RegWrite with dest 0 at WB (force o_wb_RegWrite=0 when dest=0).

Reset
REQ-027 SHALL clear all stage registers to 0 immediately on i_reset=0, independent of i_clk; all outputs 0 including o_stall.
REQ-028 SHALL resume decode on the first rising edge after i_reset returns high; a reset mid-stall discards the stall.

Verification
REQ-029 SHALL cover: ADD rs=1 rt=2 rd=3 valid -> cycle+1 ALUop=0 RegDst=1; cycle+3 RegWrite=1 dest=3 MemtoReg=0.
REQ-030 SHALL cover: LW rt=4 then ADD rs=4 -> o_stall=1 one cycle, EX bubble, ADD reaches WB at cycle 5 after LW's ID.
REQ-031 SHALL cover: LW rt=4 with i_flush on next ADD rs=4 -> o_stall=0, EX bubble, LW completes with MemRead=1, type=011.
REQ-032 SHALL cover: i_halt high 3 cycles mid-stream -> all stage outputs frozen, o_stall=1, resume with no lost instruction.
REQ-033 SHALL cover: op=6'b111111 -> cycle+1 o_ex_illegal=1, no RegWrite/MemWrite in later stages.
REQ-034 SHALL cover: i_reset low between edges mid-pipeline -> outputs 0 at once; JAL after release -> WB dest=31 RegWrite=1.
